// File: rtl/arm_pkg.sv
// Shared ARM pipeline types and constants for the memory stage.
// Pure declarations, no timing behaviour of its own.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
    localparam int          SRAM_DW       = 16;

endpackage

// File: rtl/mem_sram_stage_if.sv
// Pipeline-side bundle of the memory stage: execute-stage request in, freeze/result out.
// ready low stalls the pipeline registers feeding this bundle.
interface mem_sram_stage_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic        ready;
    logic [31:0] MEM_Res;

    modport master (output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, input ready, MEM_Res);
    modport slave  (input MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, output ready, MEM_Res);
endinterface

// File: rtl/mem_sram_stage.sv
// 32-bit load/store over a 16-bit async SRAM as two half-word accesses (2*WAIT_CYCLES+3 cycles).
// ready stays low for the whole access so upstream stages freeze; requests are latched in IDLE.
module mem_sram_stage
    import arm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    mem_sram_stage_if.slave     pipe,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] idx_q, idx_d;
    logic               st_q, st_d;
    logic [31:0]        dat_q, dat_d;
    logic [15:0]        lo_q, lo_d;
    logic [31:0]        res_q, res_d;

    logic               req;
    logic               last;
    logic               act;
    logic               dq_oe;
    logic [15:0]        dq_out;
    logic [31:0]        word;
    logic               unused_word_bits;

    assign req  = pipe.MEM_R_EN | pipe.MEM_W_EN;
    // Below-base addresses wrap modulo 2^32 before truncation.
    assign word = (pipe.ALU_Res - BASE_ADDR) >> 2;
    assign unused_word_bits = ^word[31:SRAM_AW-1];
    assign last = (cnt_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        st_d    = st_q;
        dat_d   = dat_q;
        lo_d    = lo_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LO;
                    cnt_d   = 3'd0;
                    idx_d   = word[SRAM_AW-2:0];
                    st_d    = pipe.MEM_W_EN;
                    dat_d   = pipe.Val_Rm;
                end
            end
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = 3'd0;
                    if (!st_q) lo_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    if (!st_q) res_d = {SRAM_DQ, lo_q};
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            st_q    <= 1'b0;
            dat_q   <= 32'd0;
            lo_q    <= 16'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            st_q    <= st_d;
            dat_q   <= dat_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
        end
    end

    // SRAM pins depend only on registered state, so they are glitch-free of pipeline inputs.
    always_comb begin
        act       = (state_q == LO) || (state_q == HI);
        SRAM_ADDR = act ? {idx_q, state_q == HI} : '0;
        SRAM_WE_N = ~(act & st_q);
        SRAM_OE_N = ~(act & ~st_q);
        dq_oe     = act & st_q;
        dq_out    = (state_q == HI) ? dat_q[31:16] : dat_q[15:0];
    end

    assign SRAM_DQ      = dq_oe ? dq_out : 16'bz;
    assign pipe.ready   = ~req | (state_q == DONE);
    assign pipe.MEM_Res = res_q;

endmodule

// File: doc/mem_sram_stage.md
# mem_sram_stage

Memory stage of the ARM pipeline, directly downstream of the execute stage. It consumes the ALU result as a byte address and the forwarded Rm value as store data, and performs 32-bit loads and stores on a 16-bit-wide external asynchronous SRAM. Each word access takes two half-word accesses. While an access is in flight, `ready` drops so that the hazard/freeze logic stalls every upstream pipeline register.

## Interface
- `BASE_ADDR`, 32'd1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM half-word address width.
- `WAIT_CYCLES`, 0: extra cycles each half-word access is held (0–7).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `MEM_R_EN` in 1: load request.
- `MEM_W_EN` in 1: store request.
- `ALU_Res` in 32: byte address from the execute stage.
- `Val_Rm` in 32: store data from the execute stage (already forwarded).
- `ready` out 1: 0 means freeze the pipeline.
- `MEM_Res` out 32: last loaded word.
- `SRAM_ADDR` out SRAM_AW: half-word address.
- `SRAM_DQ` inout 16: data bus.
- `SRAM_WE_N` out 1: write enable, active low.
- `SRAM_OE_N` out 1: output enable, active low.

## Operation
- **Request and address math**
  - A request is present when `MEM_R_EN | MEM_W_EN`.
  - If both are 1, the access is treated as a store.
  - Word index = `(ALU_Res - BASE_ADDR) >> 2`, computed mod 2^32 and then truncated to SRAM_AW-1 bits. Addresses below the base wrap; no error is raised.
  - Low half address = `{idx, 1'b0}`. High half address = `{idx, 1'b1}`.
- **FSM states**
  - IDLE: with a request → LO. The block latches the address, op and `Val_Rm` into internal registers.
  - LO: held for WAIT_CYCLES+1 cycles, counted by a wait counter → HI.
  - HI: held for WAIT_CYCLES+1 cycles → DONE.
  - DONE: unconditionally → IDLE after one cycle.
- **ready**: combinational. `ready = ~(MEM_R_EN | MEM_W_EN) | (state == DONE)`.
- **SRAM outputs**: decoded from registered state only.
  - Outside LO/HI: `SRAM_ADDR` = 0, `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, DQ tri-stated.
  - Load: `SRAM_OE_N` = 0 in LO/HI; DQ tri-stated.
  - Store: `SRAM_WE_N` = 0 in LO/HI. DQ drives latched data [15:0] in LO and [31:16] in HI.
- **Load data capture**
  - Low half is captured on the last edge of LO; high half on the last edge of HI.
  - `MEM_Res` updates to `{hi, lo}` on the edge entering DONE.
  - `MEM_Res` holds until the next completed load. Stores never modify it.
- **Reset**: asynchronous and effective mid-access. state = IDLE, counter = 0, latches = 0, `MEM_Res` = 0, `SRAM_WE_N` = 1, `SRAM_OE_N` = 1, DQ tri-stated. A store interrupted by reset leaves SRAM content undefined for that word.

## Timing
- Let W = WAIT_CYCLES, and let cycle 0 be the cycle in which a request is first seen in IDLE.
  - LO: cycles 1..W+1.
  - HI: cycles W+2..2W+2.
  - DONE: cycle 2W+3.
- `ready` is 0 in cycles 0..2W+2 and 1 in cycle 2W+3. With W=0 that is 3 stall cycles and a result in cycle 3.
- **Back-to-back requests**: the pipeline advances at the end of DONE, and a new request present in the following cycle starts a new cycle 0. There is no bubble beyond IDLE.
- **Input changes**: the address, data and op are latched, so input changes during LO/HI are ignored. Requests dropping mid-access do not abort the access.
- **Non-memory instructions**: `ready` = 1 and zero latency. Outputs stay at their idle values.

## Structure
- Shared package `arm_pkg`:
  - state enum (IDLE, LO, HI, DONE);
  - the `BASE_ADDR` default;
  - the SRAM width constant (16).
- Single module. The wait counter is inline (3 bits). No sub-module is warranted.
- The bench uses a behavioural SRAM model with a 2^SRAM_AW × 16 array. The model honours WE_N/OE_N.

## Test plan
- **Store, W=0**: `ALU_Res`=1032, `Val_Rm`=0xDEADBEEF, `MEM_W_EN`=1 → `ready` 0,0,0,1. SRAM[4]=0xBEEF and SRAM[5]=0xDEAD. `MEM_Res` unchanged.
- **Load after store**: `ALU_Res`=1032, `MEM_R_EN`=1 → `ready` low for 3 cycles, then `MEM_Res`=0xDEADBEEF in cycle 3.
- **W=2 load**: `ready` low for exactly 7 cycles. Each half's address is held for 3 cycles.
- **No request**: `ready`=1 and `SRAM_WE_N`=`SRAM_OE_N`=1 on every cycle. `MEM_Res` holds its value.
- **Reset during HI of a store**: next cycle shows state IDLE, `SRAM_WE_N`=1, DQ=Z, `MEM_Res`=0. A following load completes normally.
- **Back-to-back**: store to 1024 then load from 1028 with no gap → the second access starts the cycle after DONE. Total 8 cycles with W=0.
